// File: rtl/ball_motion.sv
// ball_motion: per-frame position/direction/life state for BALL_NUM balls.
// A tick starts a one-hot walk that moves one ball per cycle; docked balls follow the paddle.
module ball_motion #(
   parameter int BALL_NUM = 2,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int PADDLE_Y = 440
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tick,
   input  logic                   serve,
   input  logic                   launch,
   input  logic                   split,
   input  logic [9:0]             paddle_x,
   input  logic [3:0]             speed,
   input  logic [5:0]             radius,
   input  logic [BALL_NUM-1:0]    flip_x,
   input  logic [BALL_NUM-1:0]    flip_y,
   output logic [BALL_NUM*10-1:0] xs,
   output logic [BALL_NUM*10-1:0] ys,
   output logic [BALL_NUM-1:0]    active,
   output logic                   busy,
   output logic                   ball_lost,
   output logic                   all_lost
);
   typedef enum logic [1:0] {B_OFF, B_DOCKED, B_MOVING} ball_st_e;

   localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1);
   localparam logic [9:0]         PAD_Y = 10'(PADDLE_Y);

   ball_st_e st_q [BALL_NUM];
   ball_st_e st_d [BALL_NUM];
   logic [BALL_NUM-1:0][9:0] x_q, x_d, y_q, y_d;
   logic [BALL_NUM-1:0] vxn_q, vxn_d, vyn_q, vyn_d;  // 1 = heading toward -x / -y
   logic [BALL_NUM-1:0] fx_q, fx_d, fy_q, fy_d;
   logic [BALL_NUM-1:0] walk_q, walk_d, mask_q, mask_d;
   logic [BALL_NUM-1:0] moving, live_d, neg_x, neg_y;
   logic lost_q, lost_d, all_q, all_d;
   logic all_off;
   logic signed [11:0] sp, rad;
   logic signed [11:0] nx [BALL_NUM];
   logic signed [11:0] ny [BALL_NUM];

   // Candidate positions use the direction after any pending flip is applied.
   always_comb begin
      sp      = $signed({8'd0, speed});
      rad     = $signed({6'd0, radius});
      all_off = 1'b1;
      for (int i = 0; i < BALL_NUM; i++) begin
         moving[i] = (st_q[i] == B_MOVING);
         if (st_q[i] != B_OFF) all_off = 1'b0;
         neg_x[i] = vxn_q[i] ^ fx_q[i];
         neg_y[i] = vyn_q[i] ^ fy_q[i];
         nx[i] = neg_x[i] ? $signed({2'b00, x_q[i]}) - sp : $signed({2'b00, x_q[i]}) + sp;
         ny[i] = neg_y[i] ? $signed({2'b00, y_q[i]}) - sp : $signed({2'b00, y_q[i]}) + sp;
      end
   end

   always_comb begin
      st_d   = st_q;
      x_d    = x_q;
      y_d    = y_q;
      vxn_d  = vxn_q;
      vyn_d  = vyn_q;
      walk_d = walk_q << 1;
      mask_d = mask_q;
      lost_d = 1'b0;
      fx_d   = (fx_q | flip_x) & moving;
      fy_d   = (fy_q | flip_y) & moving;

      // Mask snapshots who was MOVING at the tick, so a same-cycle launch waits a frame.
      if (tick && walk_q == '0) begin
         walk_d    = '0;
         walk_d[0] = 1'b1;
         mask_d    = moving;
      end

      if (serve) begin
         if (all_off) st_d[0] = B_DOCKED;
      end else if (launch) begin
         for (int i = 0; i < BALL_NUM; i++)
            if (st_q[i] == B_DOCKED) st_d[i] = B_MOVING;
      end else if (split && moving[0]) begin
         for (int i = 1; i < BALL_NUM; i++)
            if (st_q[i] == B_OFF) begin
               st_d[i]  = B_MOVING;
               x_d[i]   = x_q[0];
               y_d[i]   = y_q[0];
               vxn_d[i] = ~vxn_q[0];
               vyn_d[i] = vyn_q[0];
            end
      end

      for (int i = 0; i < BALL_NUM; i++) begin
         if (walk_q[i] && mask_q[i] && moving[i]) begin
            fx_d[i] = flip_x[i];
            fy_d[i] = flip_y[i];
            if (nx[i] - rad <= 12'sd0) begin
               x_d[i]   = {4'd0, radius};
               vxn_d[i] = 1'b0;
            end else if (nx[i] + rad >= X_MAX) begin
               x_d[i]   = 10'(X_MAX - rad);
               vxn_d[i] = 1'b1;
            end else begin
               x_d[i]   = nx[i][9:0];
               vxn_d[i] = neg_x[i];
            end
            if (ny[i] - rad <= 12'sd0) begin
               y_d[i]   = {4'd0, radius};
               vyn_d[i] = 1'b0;
            end else if (ny[i] - rad > Y_MAX) begin
               st_d[i] = B_OFF;
               lost_d  = 1'b1;
               fx_d[i] = 1'b0;
               fy_d[i] = 1'b0;
            end else begin
               y_d[i]   = ny[i][9:0];
               vyn_d[i] = neg_y[i];
            end
         end
      end

      for (int i = 0; i < BALL_NUM; i++) begin
         if (st_d[i] == B_DOCKED) begin
            x_d[i] = paddle_x;
            y_d[i] = PAD_Y - {4'd0, radius} - 10'd1;
         end
         live_d[i] = (st_d[i] != B_OFF);
      end
      all_d = lost_d && (live_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BALL_NUM; i++) st_q[i] <= B_OFF;
         x_q    <= '0;
         y_q    <= '0;
         vxn_q  <= '0;
         vyn_q  <= '1;
         fx_q   <= '0;
         fy_q   <= '0;
         walk_q <= '0;
         mask_q <= '0;
         lost_q <= 1'b0;
         all_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         x_q    <= x_d;
         y_q    <= y_d;
         vxn_q  <= vxn_d;
         vyn_q  <= vyn_d;
         fx_q   <= fx_d;
         fy_q   <= fy_d;
         walk_q <= walk_d;
         mask_q <= mask_d;
         lost_q <= lost_d;
         all_q  <= all_d;
      end
   end

   always_comb begin
      for (int i = 0; i < BALL_NUM; i++) active[i] = (st_q[i] != B_OFF);
   end

   assign xs        = x_q;
   assign ys        = y_q;
   assign busy      = |walk_q;
   assign ball_lost = lost_q;
   assign all_lost  = all_q;
endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: stimulus queues expected frames/losses, monitors pop and compare.
module tb_ball_motion;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       tick = 1'b0, serve = 1'b0, launch = 1'b0, split = 1'b0;
   logic [9:0] paddle_x = '0;
   logic [3:0] speed = '0;
   logic [5:0] radius = '0;
   logic [1:0] flip_x = '0, flip_y = '0;
   logic [19:0] xs, ys;
   logic [1:0]  active;
   logic        busy, ball_lost, all_lost;

   int checks = 0, errors = 0;

   typedef struct {
      string      nm;
      logic [1:0] act;
      bit         c0, c1;
      int         x0, y0, x1, y1;
   } exp_t;

   exp_t frame_q[$];
   exp_t probe_q[$];
   bit   loss_q[$];
   event probe_ev;

   always #5 clk = ~clk;

   ball_motion #(.BALL_NUM(2), .SCREEN_W(640), .SCREEN_H(480), .PADDLE_Y(440)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .serve(serve), .launch(launch), .split(split),
      .paddle_x(paddle_x), .speed(speed), .radius(radius), .flip_x(flip_x), .flip_y(flip_y),
      .xs(xs), .ys(ys), .active(active), .busy(busy), .ball_lost(ball_lost), .all_lost(all_lost)
   );

   function automatic exp_t mk(input string nm, input logic [1:0] act,
                               input bit c0, input int x0, input int y0,
                               input bit c1, input int x1, input int y1);
      exp_t e;
      e.nm = nm; e.act = act; e.c0 = c0; e.c1 = c1;
      e.x0 = x0; e.y0 = y0; e.x1 = x1; e.y1 = y1;
      return e;
   endfunction

   task automatic cmp(input exp_t e);
      bit ok;
      checks++;
      ok = (active == e.act);
      if (e.c0 && (xs[9:0] != 10'(e.x0) || ys[9:0] != 10'(e.y0))) ok = 1'b0;
      if (e.c1 && (xs[19:10] != 10'(e.x1) || ys[19:10] != 10'(e.y1))) ok = 1'b0;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got act=%b b0=(%0d,%0d) b1=(%0d,%0d) want act=%b b0=(%0d,%0d)%s b1=(%0d,%0d)%s",
                  e.nm, active, xs[9:0], ys[9:0], xs[19:10], ys[19:10], e.act,
                  e.x0, e.y0, e.c0 ? "" : "[skip]", e.x1, e.y1, e.c1 ? "" : "[skip]");
      end
   endtask

   // Walk monitor: on each busy falling edge check walk length and the queued frame.
   initial begin : frame_mon
      int blen;
      bit prev;
      blen = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (busy) blen++;
         else if (prev) begin
            checks++;
            if (blen != 2) begin
               errors++;
               $display("FAIL busy_len: got %0d cycles want 2", blen);
            end
            if (frame_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL frame_unexpected: walk ended with nothing queued");
            end else cmp(frame_q.pop_front());
            blen = 0;
         end
         prev = busy;
      end
   end

   initial begin : loss_mon
      bit w;
      forever begin
         @(negedge clk);
         if (ball_lost) begin
            checks++;
            if (loss_q.size() == 0) begin
               errors++;
               $display("FAIL loss_unexpected: ball_lost=1 all_lost=%b with nothing queued", all_lost);
            end else begin
               w = loss_q.pop_front();
               if (all_lost !== w) begin
                  errors++;
                  $display("FAIL all_lost: got %b want %b", all_lost, w);
               end
            end
         end else if (all_lost) begin
            checks++;
            errors++;
            $display("FAIL all_lost_alone: got all_lost=1 want 0 without ball_lost");
         end
      end
   end

   initial begin : probe_mon
      forever begin
         @(probe_ev);
         if (probe_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL probe_empty: got event want queued expectation");
         end else cmp(probe_q.pop_front());
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_n = 1'b0; tick = 1'b0; serve = 1'b0; launch = 1'b0; split = 1'b0;
      flip_x = '0; flip_y = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic probe(input exp_t e);
      @(negedge clk);
      probe_q.push_back(e);
      -> probe_ev;
      #1;
   endtask

   // which: 0 serve, 1 launch, 2 split
   task automatic pulse(input int which);
      @(negedge clk);
      case (which)
         0: serve = 1'b1;
         1: launch = 1'b1;
         default: split = 1'b1;
      endcase
      @(negedge clk);
      serve = 1'b0; launch = 1'b0; split = 1'b0;
   endtask

   task automatic pulse_fy(input logic [1:0] v);
      @(negedge clk) flip_y = v;
      @(negedge clk) flip_y = '0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL walk_timeout: got busy stuck want idle within 20 cycles");
      end
   endtask

   task automatic walk(input exp_t e);
      frame_q.push_back(e);
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      wait_idle();
   endtask

   initial begin
      do_reset();
      // docking, tracking, launch-with-tick, slow moves
      probe(mk("reset", 2'b00, 1, 0, 0, 1, 0, 0));
      radius = 6'd4; paddle_x = 10'd320; speed = 4'd2;
      pulse(0);
      probe(mk("docked", 2'b01, 1, 320, 435, 1, 0, 0));
      paddle_x = 10'd100;
      probe(mk("track", 2'b01, 1, 100, 435, 0, 0, 0));
      paddle_x = 10'd320;
      @(negedge clk);
      frame_q.push_back(mk("launch_tick", 2'b01, 1, 320, 435, 0, 0, 0));
      @(negedge clk) begin launch = 1'b1; tick = 1'b1; end
      @(negedge clk) begin launch = 1'b0; tick = 1'b0; end
      wait_idle();
      walk(mk("mv1", 2'b01, 1, 322, 433, 1, 0, 0));
      walk(mk("mv2", 2'b01, 1, 324, 431, 0, 0, 0));
      walk(mk("mv3", 2'b01, 1, 326, 429, 0, 0, 0));

      // right-wall bounce
      speed = 4'd4;
      for (int k = 1; k <= 77; k++)
         walk(mk($sformatf("run_%0d", k), 2'b01, 1, 326 + 4 * k, 429 - 4 * k, 0, 0, 0));
      walk(mk("rwall", 2'b01, 1, 635, 117, 0, 0, 0));
      walk(mk("rwall_back", 2'b01, 1, 631, 113, 0, 0, 0));

      // sticky flip_y
      do_reset();
      probe(mk("reset2", 2'b00, 1, 0, 0, 1, 0, 0));
      radius = 6'd4; paddle_x = 10'd320; speed = 4'd5;
      pulse(0);
      pulse(1);
      for (int k = 1; k <= 47; k++)
         walk(mk($sformatf("up_%0d", k), 2'b01, 1, 320 + 5 * k, 435 - 5 * k, 0, 0, 0));
      speed = 4'd3;
      pulse_fy(2'b01);
      walk(mk("flip1", 2'b01, 1, 558, 203, 0, 0, 0));
      walk(mk("flip2", 2'b01, 1, 561, 206, 0, 0, 0));

      // split, top bounce, single loss
      do_reset();
      radius = 6'd4; paddle_x = 10'd65; speed = 4'd5;
      pulse(0);
      pulse(1);
      for (int k = 1; k <= 47; k++)
         walk(mk($sformatf("pre_%0d", k), 2'b01, 1, 65 + 5 * k, 435 - 5 * k, 0, 0, 0));
      pulse(2);
      probe(mk("split", 2'b11, 1, 300, 200, 1, 300, 200));
      pulse_fy(2'b10);
      for (int k = 1; k <= 57; k++) begin
         case (k)
            1:  walk(mk("sp_1", 2'b11, 1, 305, 195, 1, 295, 205));
            40: walk(mk("sp_top", 2'b11, 1, 500, 4, 1, 100, 400));
            56: walk(mk("sp_56", 2'b11, 1, 580, 84, 1, 20, 480));
            57: begin
               loss_q.push_back(1'b0);
               walk(mk("sp_lost1", 2'b01, 1, 585, 89, 0, 0, 0));
            end
            default: walk(mk($sformatf("sp_%0d", k), 2'b11, 0, 0, 0, 0, 0, 0));
         endcase
      end

      // last ball lost, tick during busy ignored
      do_reset();
      radius = 6'd2; paddle_x = 10'd320; speed = 4'd5;
      pulse(0);
      probe(mk("docked_r2", 2'b01, 1, 320, 437, 0, 0, 0));
      pulse(1);
      pulse_fy(2'b01);
      for (int k = 1; k <= 5; k++)
         walk(mk($sformatf("dn5_%0d", k), 2'b01, 1, 320 + 5 * k, 437 + 5 * k, 0, 0, 0));
      speed = 4'd4;
      for (int k = 1; k <= 4; k++)
         walk(mk($sformatf("dn4_%0d", k), 2'b01, 1, 345 + 4 * k, 462 + 4 * k, 0, 0, 0));
      loss_q.push_back(1'b1);
      frame_q.push_back(mk("all_lost", 2'b00, 0, 0, 0, 0, 0, 0));
      @(negedge clk) tick = 1'b1;
      @(negedge clk);
      @(negedge clk) tick = 1'b0;
      wait_idle();
      repeat (8) @(negedge clk);

      checks++;
      if (frame_q.size() != 0 || loss_q.size() != 0 || probe_q.size() != 0) begin
         errors++;
         $display("FAIL leftovers: got frames=%0d losses=%0d probes=%0d want 0 0 0",
                  frame_q.size(), loss_q.size(), probe_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
